// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: synchronises and debounces the driver switches, arbitrates the
// request and emits a glitch-free state_select code plus the clock_led strobe.
module turn_signal_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LED_DIV         = 12500000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_hazard,
    output logic       clock_led,
    output logic [2:0] state_select,
    output logic       active
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LW = LED_DIV > 1 ? $clog2(LED_DIV) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] DIV_LAST = LW'(LED_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HAZ   = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        GAP   = 3'd4
    } state_t;

    // bit 0 = left, bit 1 = right, bit 2 = hazard
    logic [2:0]    sync1, sync2, level;
    logic [DW-1:0] db_cnt [3];
    logic [LW-1:0] div_cnt;
    logic          upd;
    state_t        state, req, next;
    logic [2:0]    sel_next;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {sw_hazard, sw_right, sw_left};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        req = (level[2] || (level[0] && level[1])) ? HAZ :
              level[0] ? LEFT : level[1] ? RIGHT : IDLE;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            div_cnt   <= '0;
            clock_led <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            clock_led <= ~clock_led;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // updating on the clock_led falling edge leaves a full half-period of setup
    assign upd = (div_cnt == DIV_LAST) && clock_led;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            state_select <= 3'b000;
            active       <= 1'b0;
        end else if (upd) begin
            state        <= next;
            state_select <= sel_next;
            active       <= |sel_next;
        end
    end

    // a switch between two active modes passes through GAP so the sequencer restarts
    always_comb begin
        next = (state == IDLE || state == GAP || req == state) ? req :
               (req == IDLE) ? IDLE : GAP;
    end

    always_comb begin
        sel_next = (next == GAP) ? 3'b000 : next;
    end
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// tb_turn_signal_ctrl: directed steps with a scoreboard of expected codes that is
// drained at clock_led edges.
module tb_turn_signal_ctrl;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       sw_left = 1'b0, sw_right = 1'b0, sw_hazard = 1'b0;
    logic       clock_led, active;
    logic [2:0] state_select;
    int         passed = 0, total = 0;
    logic [3:0] sb [$];

    turn_signal_ctrl #(.DEBOUNCE_CYCLES(3), .LED_DIV(4)) dut (
        .clock(clock),
        .resetn(resetn),
        .sw_left(sw_left),
        .sw_right(sw_right),
        .sw_hazard(sw_hazard),
        .clock_led(clock_led),
        .state_select(state_select),
        .active(active)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_led(input logic lvl, output int n);
        logic prev;
        n = 0;
        forever begin
            prev = clock_led;
            tick(1);
            n++;
            if (clock_led === lvl && prev !== lvl) return;
            if (n >= 40) begin
                total++;
                $error("FAIL led_timeout observed=%0d cycles expected=edge to %0b", n, lvl);
                return;
            end
        end
    endtask

    task automatic push(input logic [2:0] s);
        sb.push_back({|s, s});
    endtask

    task automatic sb_check(input string tag, input logic lvl);
        int n;
        logic [3:0] e;
        wait_led(lvl, n);
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s observed=empty scoreboard expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_sel"}, 32'(state_select), 32'(e[2:0]));
        check({tag, "_act"}, 32'(active), 32'(e[3]));
    endtask

    initial begin
        int  n;
        bit  bad;
        tick(5);
        check("rst_led", 32'(clock_led), 0);
        check("rst_sel", 32'(state_select), 0);
        check("rst_act", 32'(active), 0);
        resetn = 1'b1;
        tick(3);
        check("led_low_c3", 32'(clock_led), 0);
        tick(1);
        check("led_rise_c4", 32'(clock_led), 1);
        wait_led(1'b1, n);
        check("led_period", 32'(n), 8);

        sw_left = 1'b1;
        tick(2);
        sw_left = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            tick(1);
            if (state_select !== 3'b000) bad = 1'b1;
        end
        check("glitch", 32'(bad), 0);

        wait_led(1'b0, n);
        sw_left = 1'b1;
        push(3'b010);
        sb_check("left_fall", 1'b0);
        push(3'b010);
        sb_check("left_rise1", 1'b1);
        push(3'b010);
        sb_check("left_rise2", 1'b1);

        wait_led(1'b0, n);
        sw_left  = 1'b0;
        sw_right = 1'b1;
        push(3'b000);
        sb_check("l2r_gap_fall", 1'b0);
        push(3'b000);
        sb_check("l2r_gap_rise", 1'b1);
        push(3'b011);
        sb_check("l2r_right", 1'b0);

        sw_left = 1'b1;
        push(3'b000);
        sb_check("r2h_gap", 1'b0);
        push(3'b001);
        sb_check("both_haz", 1'b0);
        sw_hazard = 1'b1;
        push(3'b001);
        sb_check("haz_plus", 1'b0);
        sw_left   = 1'b0;
        sw_right  = 1'b0;
        sw_hazard = 1'b0;
        push(3'b000);
        sb_check("haz_idle", 1'b0);

        sw_right = 1'b1;
        push(3'b011);
        sb_check("right_again", 1'b0);
        push(3'b011);
        sb_check("right_rise", 1'b1);
        check("mid_led_high", 32'(clock_led), 1);
        resetn = 1'b0;
        tick(1);
        check("mid_rst_led", 32'(clock_led), 0);
        check("mid_rst_sel", 32'(state_select), 0);
        check("mid_rst_act", 32'(active), 0);
        resetn = 1'b1;
        tick(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/turn_signal_ctrl.md
Name: turn_signal_ctrl

Overview:
- Front-end controller for the tail-light sequencer.
- Samples the raw driver switches (left, right, hazard), then synchronises and debounces them.
- Arbitrates the request and produces the 3-bit state_select code together with the slow clock_led strobe clock that the sequencer consumes.
- Guarantees that state_select changes only while clock_led is low, so the sequencer never samples a changing code.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable system-clock cycles required before a synchronised switch level is accepted (10 ms at 50 MHz).
- LED_DIV, 12500000: system-clock cycles per clock_led half-period; clock_led period = 2*LED_DIV.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- sw_left  input  1  raw left-turn switch, asynchronous, active-high.
- sw_right  input  1  raw right-turn switch, asynchronous, active-high.
- sw_hazard  input  1  raw hazard switch, asynchronous, active-high.
- clock_led  output  1  divided clock, 50% duty, period 2*LED_DIV cycles.
- state_select  output  3  mode code: 000 idle, 001 hazard, 010 left, 011 right; 1xx never driven.
- active  output  1  high when state_select != 000.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - clock_led=0, state_select=000, active=0.
  - Divider count=0, FSM=IDLE.
  - Debounced levels=0, debounce counters=0, synchroniser flops=0.
  - Reset mid-frame aborts immediately, with no completion of the current frame.
- Synchroniser: two flops per switch; 2-cycle latency before the debouncer sees a change.
- Debouncer (per switch):
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - A glitch lasting fewer than DEBOUNCE_CYCLES cycles has no effect.
  - Counter width is clog2(DEBOUNCE_CYCLES) and must not overflow.
- Request decode, combinational on debounced levels, priority order:
  - hazard=1 -> HAZ;
  - else left=1 and right=1 -> HAZ;
  - else left -> LEFT;
  - else right -> RIGHT;
  - else IDLE.
- Divider:
  - div_cnt counts 0..LED_DIV-1 and wraps to 0.
  - When div_cnt==LED_DIV-1, clock_led toggles on the same edge that wraps the count.
  - The first rising edge of clock_led after reset occurs LED_DIV cycles after reset release.
- Update strobe: upd = (div_cnt==LED_DIV-1) && clock_led==1, i.e. the edge where clock_led falls. FSM state and state_select change only on upd edges. This gives LED_DIV cycles of setup before the next clock_led rise.
- FSM states: IDLE(000), HAZARD(001), LEFT(010), RIGHT(011), GAP(000). state_select is a registered function of state.
- Transitions, evaluated only at upd:
  - IDLE -> request state (stays in IDLE if the request is IDLE).
  - HAZARD/LEFT/RIGHT, request unchanged -> stay.
  - HAZARD/LEFT/RIGHT, request IDLE -> IDLE.
  - LEFT<->RIGHT, HAZARD->LEFT/RIGHT, LEFT/RIGHT->HAZARD -> GAP. GAP forces one full clock_led period of 000 so the sequencer counter restarts.
  - GAP -> current request, re-evaluated at the next upd; may be IDLE.
- Requests that change and change back between two upd strobes are not seen.
- active is registered alongside state_select.

Test Plan:
- Test parameters for all scenarios: DEBOUNCE_CYCLES=3, LED_DIV=4.
- Reset: hold resetn=0 for 5 cycles, then release -> clock_led=0, state_select=000, active=0; clock_led first rises at cycle 4 after release and has period 8.
- Glitch rejection: sw_left high for 2 cycles, then low -> state_select stays 000 for 40 cycles.
- Left request: sw_left held high -> at the first clock_led falling edge after debounce, state_select=010 and active=1; the value is stable across every subsequent clock_led rising edge.
- Left to right: while in 010, drop sw_left and raise sw_right -> exactly one clock_led period (8 cycles) at 000, then 011 at the next falling edge.
- Hazard priority: sw_left=sw_right=1 -> code 001; adding sw_hazard keeps 001; releasing all -> 000 at the next falling edge with no GAP.
- Reset mid-operation: assert resetn=0 while in 011 with clock_led=1 -> on the next edge, clock_led=0 and state_select=000.
